scr1_ahb_mem_slv: RTL and testbench
===================================

SCR1_AHB_MEM_SLV -- requirements
Module: scr1_ahb_mem_slv

Interface
REQ-001 Parameters: none; widths come from the shared AHB/memif package (SCR1_AHB_WIDTH = 32).
REQ-002 clk  in  1  clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 hsel  in  1  slave select.
REQ-005 htrans  in  2  AHB transfer type (IDLE/BUSY/NONSEQ/SEQ).
REQ-006 hwrite  in  1  1 = write.
REQ-007 hsize  in  3  transfer size (8b/16b/32b legal).
REQ-008 haddr  in  32  address.
REQ-009 hwdata  in  32  write data, valid in data phase.
REQ-010 hready  in  1  bus-level HREADY (previous transfer complete).
REQ-011 hreadyout  out  1  slave ready.
REQ-012 hrdata  out  32  read data.
REQ-013 hresp  out  1  OKAY/ERROR.
REQ-014 mem_req  out  1  memory request.
REQ-015 mem_req_ack  in  1  request accepted.
REQ-016 mem_cmd  out  1  read/write (type_scr1_mem_cmd_e).
REQ-017 mem_width  out  2  byte/hword/word (type_scr1_mem_width_e).
REQ-018 mem_addr  out  32  request address.
REQ-019 mem_wdata  out  32  write data.
REQ-020 mem_rdata  in  32  read data.
REQ-021 mem_resp  in  2  NOTRDY/RDY_OK/RDY_ER (type_scr1_mem_resp_e).

Function
REQ-022 Address phase accepted when hsel & hready & htrans[1]; haddr, hwrite, hsize registered at that edge; otherwise no state change from idle.
REQ-023 FSM states: IDLE, REQ, RESP, ERR1, ERR2.
REQ-024 IDLE: hreadyout=1, hresp=OKAY; accepted legal transfer -> REQ; accepted illegal transfer -> ERR1.
REQ-025 Illegal transfer: hsize>32b, or halfword with haddr[0]=1, or word with haddr[1:0]!=0; no mem_req is issued for it.
REQ-026 REQ: mem_req=1, mem_addr/mem_cmd/mem_width from registered phase, mem_wdata=hwdata (combinational); hreadyout=0; mem_req_ack=1 -> RESP.
REQ-027 RESP: mem_req=0, hreadyout=0 while mem_resp=NOTRDY.
REQ-028 RESP with mem_resp=RDY_OK: hreadyout=1, hresp=OKAY, hrdata=mem_rdata same cycle; next state REQ/ERR1/IDLE per REQ-022/REQ-025 evaluation of the pipelined address phase in that cycle.
REQ-029 RESP with mem_resp=RDY_ER: hreadyout=0, hresp=ERROR -> ERR2.
REQ-030 ERR1 (illegal transfer): hreadyout=0, hresp=ERROR -> ERR2.
REQ-031 ERR2: hreadyout=1, hresp=ERROR; address phase sampled here is accepted per REQ-022 (master may cancel with IDLE).
REQ-032 Minimum latency: address phase cycle N, mem_req at N+1, earliest hreadyout=1 at N+2 (one wait state minimum).
REQ-033 hrdata = 0 outside RESP-with-RDY_OK cycles.
REQ-034 htrans BUSY/IDLE with hsel=1: zero-wait OKAY, no memory access.
REQ-035 mem_req held with stable attributes until mem_req_ack; never deasserted unacknowledged.

Reset
REQ-036 Reset: state=IDLE, hreadyout=1, hresp=OKAY, mem_req=0, registered phase cleared to 0.
REQ-037 Reset mid-transfer abandons it; no response issued after reset release; memory-side late response ignored in IDLE.

Structure
REQ-038 HTRANS/HSIZE/HRESP encodings and SCR1_AHB_WIDTH from scr1_ahb.svh; mem cmd/width/resp enums from scr1_memif.svh; FSM enum local.
REQ-039 Single flat module; no sub-module.

Verification
REQ-040 Word read 0x100, mem_req_ack immediate, RDY_OK next cycle with 0xDEADBEEF -> hreadyout high at N+2, hrdata=0xDEADBEEF, hresp=OKAY.
REQ-041 Byte write 0x203 data 0x000000A5 -> mem_cmd=WR, mem_width=BYTE, mem_addr=0x203, mem_wdata=0x000000A5.
REQ-042 Word read 0x102 -> no mem_req; hresp=ERROR two cycles, hreadyout 0 then 1.
REQ-043 Back-to-back NONSEQ reads 0x0, 0x4 with mem_req_ack low 3 cycles -> mem_req held stable, both complete in order, no lost/duplicated request.
REQ-044 mem_resp=RDY_ER on read 0x8 -> ERR2 cycle with hresp=ERROR, next NONSEQ accepted normally.
REQ-045 rst_n asserted while in RESP -> outputs return to reset values asynchronously; subsequent transfer completes normally.

Source files
------------

// File: rtl/scr1_ahb_mem_slv_pkg.sv
// Shared AHB-Lite and memory-interface encodings for the AHB-to-memory slave bridge.
// Also holds the helpers that classify and translate an AHB address phase.
package scr1_ahb_mem_slv_pkg;

   localparam int SCR1_AHB_WIDTH = 32;

   localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] SCR1_HSIZE_8B  = 3'b000;
   localparam logic [2:0] SCR1_HSIZE_16B = 3'b001;
   localparam logic [2:0] SCR1_HSIZE_32B = 3'b010;

   localparam logic SCR1_HRESP_OKAY  = 1'b0;
   localparam logic SCR1_HRESP_ERROR = 1'b1;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10,
      SCR1_MEM_WIDTH_ERROR = 2'b11
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;

   // Sizes above a word and naturally misaligned accesses are rejected on the bus.
   function automatic logic ahb_xfer_legal(input logic [2:0] size, input logic [1:0] addr_lsb);
      logic legal;
      legal = 1'b0;
      case (size)
         SCR1_HSIZE_8B:  legal = 1'b1;
         SCR1_HSIZE_16B: legal = (addr_lsb[0] == 1'b0);
         SCR1_HSIZE_32B: legal = (addr_lsb == 2'b00);
         default:        legal = 1'b0;
      endcase
      return legal;
   endfunction

   function automatic type_scr1_mem_width_e ahb_size2width(input logic [2:0] size);
      type_scr1_mem_width_e width;
      width = SCR1_MEM_WIDTH_ERROR;
      case (size)
         SCR1_HSIZE_8B:  width = SCR1_MEM_WIDTH_BYTE;
         SCR1_HSIZE_16B: width = SCR1_MEM_WIDTH_HWORD;
         SCR1_HSIZE_32B: width = SCR1_MEM_WIDTH_WORD;
         default:        width = SCR1_MEM_WIDTH_ERROR;
      endcase
      return width;
   endfunction

endpackage

// File: rtl/scr1_ahb_mem_slv.sv
// AHB-Lite slave bridging single transfers onto the request/response memory interface.
// One memory request per accepted address phase; illegal phases get a two-cycle ERROR.
module scr1_ahb_mem_slv
   import scr1_ahb_mem_slv_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      hsel,
   input  logic [1:0]                htrans,
   input  logic                      hwrite,
   input  logic [2:0]                hsize,
   input  logic [SCR1_AHB_WIDTH-1:0] haddr,
   input  logic [SCR1_AHB_WIDTH-1:0] hwdata,
   input  logic                      hready,
   output logic                      hreadyout,
   output logic [SCR1_AHB_WIDTH-1:0] hrdata,
   output logic                      hresp,
   output logic                      mem_req,
   input  logic                      mem_req_ack,
   output logic                      mem_cmd,
   output logic [1:0]                mem_width,
   output logic [SCR1_AHB_WIDTH-1:0] mem_addr,
   output logic [SCR1_AHB_WIDTH-1:0] mem_wdata,
   input  logic [SCR1_AHB_WIDTH-1:0] mem_rdata,
   input  logic [1:0]                mem_resp
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_RESP = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_e;

   state_e                    state_reg;
   state_e                    state_next;
   logic [SCR1_AHB_WIDTH-1:0] addr_reg;
   logic                      write_reg;
   logic [2:0]                size_reg;

   logic                      addr_accept;
   logic                      addr_legal;
   logic                      phase_load;
   state_e                    phase_state;

   assign addr_accept = hsel & hready
                      & ((htrans == SCR1_HTRANS_NONSEQ) | (htrans == SCR1_HTRANS_SEQ));
   assign addr_legal  = ahb_xfer_legal(hsize, haddr[1:0]);

   // Destination for a pipelined address phase seen in a cycle that completes on the bus.
   always_comb begin
      phase_state = ST_IDLE;
      if (addr_accept) begin
         phase_state = addr_legal ? ST_REQ : ST_ERR1;
      end
   end

   always_comb begin
      state_next = state_reg;
      hreadyout  = 1'b1;
      hresp      = SCR1_HRESP_OKAY;
      hrdata     = '0;
      mem_req    = 1'b0;
      phase_load = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            phase_load = addr_accept;
            state_next = phase_state;
         end
         ST_REQ: begin
            hreadyout = 1'b0;
            mem_req   = 1'b1;
            if (mem_req_ack) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            hreadyout = 1'b0;
            if (mem_resp == SCR1_MEM_RESP_RDY_OK) begin
               hreadyout  = 1'b1;
               hrdata     = mem_rdata;
               phase_load = addr_accept;
               state_next = phase_state;
            end else if (mem_resp == SCR1_MEM_RESP_RDY_ER) begin
               hresp      = SCR1_HRESP_ERROR;
               state_next = ST_ERR2;
            end
         end
         ST_ERR1: begin
            hreadyout  = 1'b0;
            hresp      = SCR1_HRESP_ERROR;
            state_next = ST_ERR2;
         end
         ST_ERR2: begin
            hresp      = SCR1_HRESP_ERROR;
            phase_load = addr_accept;
            state_next = phase_state;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         addr_reg  <= '0;
         write_reg <= 1'b0;
         size_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (phase_load) begin
            addr_reg  <= haddr;
            write_reg <= hwrite;
            size_reg  <= hsize;
         end
      end
   end

   // Attributes only change on an accepted phase, so they stay stable while mem_req waits.
   assign mem_cmd   = write_reg ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
   assign mem_width = ahb_size2width(size_reg);
   assign mem_addr  = addr_reg;
   assign mem_wdata = hwdata;

endmodule

// File: tb/tb_scr1_ahb_mem_slv.sv
// Directed bench for scr1_ahb_mem_slv: single slave on the bus, memory side driven by hand.
module tb_scr1_ahb_mem_slv;
   import scr1_ahb_mem_slv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsel;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic [31:0] hrdata;
   logic        hresp;
   logic        mem_req;
   logic        mem_req_ack;
   logic        mem_cmd;
   logic [1:0]  mem_width;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_resp;

   int n_assert = 0;
   int n_fail   = 0;

   assign hready = hreadyout;

   always #5 clk = ~clk;

   scr1_ahb_mem_slv dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hsel        (hsel),
      .htrans      (htrans),
      .hwrite      (hwrite),
      .hsize       (hsize),
      .haddr       (haddr),
      .hwdata      (hwdata),
      .hready      (hready),
      .hreadyout   (hreadyout),
      .hrdata      (hrdata),
      .hresp       (hresp),
      .mem_req     (mem_req),
      .mem_req_ack (mem_req_ack),
      .mem_cmd     (mem_cmd),
      .mem_width   (mem_width),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic addr_phase(input logic wr, input logic [2:0] size, input logic [31:0] addr);
      hsel   = 1'b1;
      htrans = SCR1_HTRANS_NONSEQ;
      hwrite = wr;
      hsize  = size;
      haddr  = addr;
   endtask

   task automatic bus_idle();
      htrans = SCR1_HTRANS_IDLE;
      hwrite = 1'b0;
      haddr  = 32'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n       = 1'b0;
      hsel        = 1'b0;
      htrans      = SCR1_HTRANS_IDLE;
      hwrite      = 1'b0;
      hsize       = SCR1_HSIZE_32B;
      haddr       = 32'h0;
      hwdata      = 32'h0;
      mem_req_ack = 1'b0;
      mem_rdata   = 32'h0;
      mem_resp    = SCR1_MEM_RESP_NOTRDY;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_hreadyout", {31'b0, hreadyout}, 32'h1);
      check("reset_hresp", {31'b0, hresp}, 32'h0);
      check("reset_mem_req", {31'b0, mem_req}, 32'h0);
      check("reset_mem_addr", mem_addr, 32'h0);
      check("reset_hrdata", hrdata, 32'h0);

      // Word read 0x100, immediate ack, RDY_OK next cycle
      @(negedge clk); addr_phase(1'b0, SCR1_HSIZE_32B, 32'h100); #1;
      check("rd100_n_hreadyout", {31'b0, hreadyout}, 32'h1);
      @(negedge clk); bus_idle(); mem_req_ack = 1'b1; #1;
      $display("txn: word read 0x100");
      check("rd100_n1_mem_req", {31'b0, mem_req}, 32'h1);
      check("rd100_n1_hreadyout", {31'b0, hreadyout}, 32'h0);
      check("rd100_n1_mem_addr", mem_addr, 32'h100);
      check("rd100_n1_mem_cmd", {31'b0, mem_cmd}, 32'h0);
      check("rd100_n1_mem_width", {30'b0, mem_width}, 32'h2);
      @(negedge clk); mem_req_ack = 1'b0; mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'hDEADBEEF; #1;
      check("rd100_n2_mem_req", {31'b0, mem_req}, 32'h0);
      check("rd100_n2_hreadyout", {31'b0, hreadyout}, 32'h1);
      check("rd100_n2_hrdata", hrdata, 32'hDEADBEEF);
      check("rd100_n2_hresp", {31'b0, hresp}, 32'h0);
      @(negedge clk); mem_resp = SCR1_MEM_RESP_NOTRDY; #1;
      check("rd100_n3_hrdata_zero", hrdata, 32'h0);
      check("rd100_n3_hreadyout", {31'b0, hreadyout}, 32'h1);

      // Byte write 0x203 data 0xA5
      @(negedge clk); addr_phase(1'b1, SCR1_HSIZE_8B, 32'h203); #1;
      @(negedge clk); bus_idle(); hwdata = 32'h000000A5; mem_req_ack = 1'b1; #1;
      $display("txn: byte write 0x203 <- 0xA5");
      check("wr203_mem_req", {31'b0, mem_req}, 32'h1);
      check("wr203_mem_cmd", {31'b0, mem_cmd}, 32'h1);
      check("wr203_mem_width", {30'b0, mem_width}, 32'h0);
      check("wr203_mem_addr", mem_addr, 32'h203);
      check("wr203_mem_wdata", mem_wdata, 32'h000000A5);
      @(negedge clk); mem_req_ack = 1'b0; mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h0; #1;
      check("wr203_hreadyout", {31'b0, hreadyout}, 32'h1);
      check("wr203_hresp", {31'b0, hresp}, 32'h0);
      @(negedge clk); mem_resp = SCR1_MEM_RESP_NOTRDY; hwdata = 32'h0; #1;

      // Misaligned word read 0x102: ERROR two cycles, no memory request
      addr_phase(1'b0, SCR1_HSIZE_32B, 32'h102); #1;
      @(negedge clk); bus_idle(); #1;
      $display("txn: misaligned word read 0x102");
      check("rd102_err1_mem_req", {31'b0, mem_req}, 32'h0);
      check("rd102_err1_hresp", {31'b0, hresp}, 32'h1);
      check("rd102_err1_hreadyout", {31'b0, hreadyout}, 32'h0);
      @(negedge clk); #1;
      check("rd102_err2_mem_req", {31'b0, mem_req}, 32'h0);
      check("rd102_err2_hresp", {31'b0, hresp}, 32'h1);
      check("rd102_err2_hreadyout", {31'b0, hreadyout}, 32'h1);
      @(negedge clk); #1;
      check("rd102_after_hresp", {31'b0, hresp}, 32'h0);

      // Misaligned halfword and oversize transfer are also rejected
      addr_phase(1'b0, SCR1_HSIZE_16B, 32'h201); #1;
      @(negedge clk); bus_idle(); #1;
      $display("txn: misaligned halfword read 0x201");
      check("hw201_mem_req", {31'b0, mem_req}, 32'h0);
      check("hw201_hresp", {31'b0, hresp}, 32'h1);
      @(negedge clk); addr_phase(1'b0, 3'b011, 32'h0); #1;
      @(negedge clk); bus_idle(); #1;
      $display("txn: 64-bit read 0x0");
      check("sz64_mem_req", {31'b0, mem_req}, 32'h0);
      check("sz64_hreadyout", {31'b0, hreadyout}, 32'h0);
      @(negedge clk); #1;
      @(negedge clk); #1;

      // BUSY with hsel: zero-wait OKAY, no memory access
      hsel = 1'b1; htrans = SCR1_HTRANS_BUSY; haddr = 32'h40; #1;
      @(negedge clk); bus_idle(); #1;
      $display("txn: BUSY");
      check("busy_mem_req", {31'b0, mem_req}, 32'h0);
      check("busy_hreadyout", {31'b0, hreadyout}, 32'h1);

      // Back-to-back reads 0x0, 0x4 with ack withheld three cycles
      @(negedge clk); addr_phase(1'b0, SCR1_HSIZE_32B, 32'h0); #1;
      @(negedge clk); addr_phase(1'b0, SCR1_HSIZE_32B, 32'h4); #1;
      $display("txn: back-to-back reads 0x0, 0x4");
      for (int i = 0; i < 3; i++) begin
         check("b2b_hold_mem_req", {31'b0, mem_req}, 32'h1);
         check("b2b_hold_mem_addr", mem_addr, 32'h0);
         @(negedge clk); #1;
      end
      mem_req_ack = 1'b1; #1;
      check("b2b_ack_mem_addr", mem_addr, 32'h0);
      @(negedge clk); mem_req_ack = 1'b0; mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h11111111; #1;
      check("b2b_first_hrdata", hrdata, 32'h11111111);
      check("b2b_first_hreadyout", {31'b0, hreadyout}, 32'h1);
      @(negedge clk); bus_idle(); mem_resp = SCR1_MEM_RESP_NOTRDY; mem_req_ack = 1'b1; #1;
      check("b2b_second_mem_req", {31'b0, mem_req}, 32'h1);
      check("b2b_second_mem_addr", mem_addr, 32'h4);
      @(negedge clk); mem_req_ack = 1'b0; mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h22222222; #1;
      check("b2b_second_hrdata", hrdata, 32'h22222222);
      check("b2b_second_mem_req", {31'b0, mem_req}, 32'h0);
      @(negedge clk); mem_resp = SCR1_MEM_RESP_NOTRDY; #1;
      check("b2b_done_mem_req", {31'b0, mem_req}, 32'h0);

      // Memory error on read 0x8, then read 0xC in the ERR2 cycle
      addr_phase(1'b0, SCR1_HSIZE_32B, 32'h8); #1;
      @(negedge clk); bus_idle(); mem_req_ack = 1'b1; #1;
      @(negedge clk); mem_req_ack = 1'b0; mem_resp = SCR1_MEM_RESP_RDY_ER; #1;
      $display("txn: read 0x8 with memory error");
      check("rder_resp_hreadyout", {31'b0, hreadyout}, 32'h0);
      check("rder_resp_hresp", {31'b0, hresp}, 32'h1);
      @(negedge clk); mem_resp = SCR1_MEM_RESP_NOTRDY; addr_phase(1'b0, SCR1_HSIZE_32B, 32'hC); #1;
      check("rder_err2_hreadyout", {31'b0, hreadyout}, 32'h1);
      check("rder_err2_hresp", {31'b0, hresp}, 32'h1);
      @(negedge clk); bus_idle(); mem_req_ack = 1'b1; #1;
      $display("txn: read 0xC after error");
      check("rd00c_mem_req", {31'b0, mem_req}, 32'h1);
      check("rd00c_mem_addr", mem_addr, 32'hC);
      check("rd00c_hresp", {31'b0, hresp}, 32'h0);
      @(negedge clk); mem_req_ack = 1'b0; mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h0000C0DE; #1;
      check("rd00c_hrdata", hrdata, 32'h0000C0DE);
      @(negedge clk); mem_resp = SCR1_MEM_RESP_NOTRDY; #1;

      // Reset asserted while waiting in RESP
      addr_phase(1'b0, SCR1_HSIZE_32B, 32'h10); #1;
      @(negedge clk); bus_idle(); mem_req_ack = 1'b1; #1;
      @(negedge clk); mem_req_ack = 1'b0; #1;
      $display("txn: read 0x10 abandoned by reset");
      check("rst_resp_hreadyout", {31'b0, hreadyout}, 32'h0);
      #1 rst_n = 1'b0; #1;
      check("rst_async_hreadyout", {31'b0, hreadyout}, 32'h1);
      check("rst_async_hresp", {31'b0, hresp}, 32'h0);
      check("rst_async_mem_req", {31'b0, mem_req}, 32'h0);
      check("rst_async_mem_addr", mem_addr, 32'h0);
      @(negedge clk); rst_n = 1'b1; mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h55555555; #1;
      check("rst_late_hrdata", hrdata, 32'h0);
      check("rst_late_hreadyout", {31'b0, hreadyout}, 32'h1);
      @(negedge clk); mem_resp = SCR1_MEM_RESP_NOTRDY; #1;
      check("rst_late_mem_req", {31'b0, mem_req}, 32'h0);
      addr_phase(1'b0, SCR1_HSIZE_16B, 32'h14); #1;
      @(negedge clk); bus_idle(); mem_req_ack = 1'b1; #1;
      $display("txn: halfword read 0x14 after reset");
      check("rd014_mem_addr", mem_addr, 32'h14);
      check("rd014_mem_width", {30'b0, mem_width}, 32'h1);
      @(negedge clk); mem_req_ack = 1'b0; mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h0000BEEF; #1;
      check("rd014_hrdata", hrdata, 32'h0000BEEF);
      check("rd014_hresp", {31'b0, hresp}, 32'h0);
      @(negedge clk); mem_resp = SCR1_MEM_RESP_NOTRDY; #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
